// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core's
// load/store port and a DMA/loader port.
//
// The CPU has priority. A DMA request that keeps losing is forced through
// after STARVE_LIMIT lost cycles; the CPU is stalled for that one cycle.
// Arbitration is combinational, so each access completes in its grant cycle.
//
// Ports:
//   CLK, Reset              clock, async active-high reset
//   cpu_req/we/addr/wdata   core request (ALUOut / WriteData / MemWrite)
//   cpu_rdata, cpu_stall    load data to the core, stall (hold PC/instr)
//   dma_req/we/addr/wdata   DMA request, held stable until dma_ack
//   dma_rdata, dma_ack      read data to the DMA, access done this cycle
//   mem_a/we/wd, mem_rd     data memory port (combinational read)
//   stall_cnt               saturating count of cpu_stall cycles
module dmem_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int STARVE_LIMIT    = 4,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [DATA_WIDTH-1:0]      cpu_addr,
    input  logic [DATA_WIDTH-1:0]      cpu_wdata,
    output logic [DATA_WIDTH-1:0]      cpu_rdata,
    output logic                       cpu_stall,
    input  logic                       dma_req,
    input  logic                       dma_we,
    input  logic [DATA_WIDTH-1:0]      dma_addr,
    input  logic [DATA_WIDTH-1:0]      dma_wdata,
    output logic [DATA_WIDTH-1:0]      dma_rdata,
    output logic                       dma_ack,
    output logic [DATA_WIDTH-1:0]      mem_a,
    output logic                       mem_we,
    output logic [DATA_WIDTH-1:0]      mem_wd,
    input  logic [DATA_WIDTH-1:0]      mem_rd,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

    localparam int WCW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WCW-1:0] LIMIT = WCW'(STARVE_LIMIT);

    logic [WCW-1:0]             wait_cnt_q, wait_cnt_d;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                       dma_gnt, cpu_gnt;

    // DMA wins when the CPU is idle or the DMA has used up its losses.
    assign dma_gnt = dma_req && (!cpu_req || wait_cnt_q == LIMIT);
    assign cpu_gnt = cpu_req && !dma_gnt;

    // Both read ports see the memory directly; each is meaningful only in
    // its owner's grant cycle.
    assign cpu_rdata = mem_rd;
    assign dma_rdata = mem_rd;

    // With no grant the CPU side is presented with writes disabled.
    // Reset masks the handshakes and the write strobe immediately.
    always_comb begin
        mem_a     = dma_gnt ? dma_addr  : cpu_addr;
        mem_wd    = dma_gnt ? dma_wdata : cpu_wdata;
        mem_we    = !Reset && (dma_gnt ? dma_we : (cpu_gnt && cpu_we));
        dma_ack   = !Reset && dma_gnt;
        cpu_stall = !Reset && cpu_req && !cpu_gnt;
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (dma_gnt || !dma_req)
            wait_cnt_d = '0;
        else if (cpu_gnt && wait_cnt_q != LIMIT)
            wait_cnt_d = wait_cnt_q + WCW'(1);

        stall_cnt_d = stall_cnt_q;
        if (cpu_stall && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for single-cycle cases plus
// hand-written sequences for starvation, idle gaps, mid-wait reset and
// stall-counter saturation (second instance, STARVE_LIMIT=1, 4-bit counter).
module tb_dmem_arbiter;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata, mem_a, mem_wd, mem_rd;
    logic        cpu_stall, dma_ack, mem_we;
    logic [15:0] stall_cnt;

    logic        c2_req, d2_req;
    logic [31:0] cpu_rdata2, dma_rdata2, mem_a2, mem_wd2;
    logic        cpu_stall2, dma_ack2, mem_we2;
    logic [3:0]  stall_cnt2;

    logic [31:0] mem [0:255];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    assign mem_rd = mem[mem_a[9:2]];
    always @(posedge CLK) if (mem_we) mem[mem_a[9:2]] <= mem_wd;

    dmem_arbiter dut (
        .CLK(CLK), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .stall_cnt(stall_cnt)
    );

    dmem_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(1), .STALL_CNT_WIDTH(4)) dut2 (
        .CLK(CLK), .Reset(Reset),
        .cpu_req(c2_req), .cpu_we(1'b1), .cpu_addr(32'h10), .cpu_wdata(32'h1),
        .cpu_rdata(cpu_rdata2), .cpu_stall(cpu_stall2),
        .dma_req(d2_req), .dma_we(1'b0), .dma_addr(32'h20), .dma_wdata(32'h2),
        .dma_rdata(dma_rdata2), .dma_ack(dma_ack2),
        .mem_a(mem_a2), .mem_we(mem_we2), .mem_wd(mem_wd2), .mem_rd(32'h1234),
        .stall_cnt(stall_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic cr, cw; logic [31:0] ca, cd;
        logic dr, dw; logic [31:0] da, dd;
        logic ack, st, we; logic [31:0] a, wd, rd;
    } vec_t;

    vec_t tbl [8];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        c2_req = 0; d2_req = 0;

        //               cr cw ca      cd        dr dw da      dd         ack st we a       wd        rd
        tbl[0] = '{1'b1,1'b1,32'h8, 32'h7,    1'b0,1'b0,32'h0, 32'h0,    1'b0,1'b0,1'b1,32'h8, 32'h7,    32'h0};
        tbl[1] = '{1'b0,1'b0,32'h0, 32'h0,    1'b1,1'b1,32'h40,32'hA5A5, 1'b1,1'b0,1'b1,32'h40,32'hA5A5, 32'h0};
        tbl[2] = '{1'b0,1'b0,32'h0, 32'h0,    1'b1,1'b0,32'h40,32'h0,    1'b1,1'b0,1'b0,32'h40,32'h0,    32'hA5A5};
        tbl[3] = '{1'b1,1'b0,32'h8, 32'h0,    1'b0,1'b0,32'h0, 32'h0,    1'b0,1'b0,1'b0,32'h8, 32'h0,    32'h7};
        tbl[4] = '{1'b0,1'b1,32'h10,32'h55,   1'b0,1'b0,32'h0, 32'h0,    1'b0,1'b0,1'b0,32'h10,32'h55,   32'h0};
        tbl[5] = '{1'b1,1'b1,32'hC, 32'h3,    1'b1,1'b1,32'h44,32'h9,    1'b0,1'b0,1'b1,32'hC, 32'h3,    32'h0};
        tbl[6] = '{1'b0,1'b0,32'h0, 32'h0,    1'b1,1'b1,32'h44,32'h9,    1'b1,1'b0,1'b1,32'h44,32'h9,    32'h0};
        tbl[7] = '{1'b0,1'b0,32'h0, 32'h0,    1'b1,1'b0,32'hC, 32'h0,    1'b1,1'b0,1'b0,32'hC, 32'h0,    32'h3};

        // Reset with both requesting and a pending store.
        Reset = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 32'h100; cpu_wdata = 32'hFFFF;
        dma_req = 1; dma_we = 1; dma_addr = 32'h80; dma_wdata = 32'h1;
        #2;
        chk("rst_mem_we", {31'b0, mem_we}, 0);
        chk("rst_stall",  {31'b0, cpu_stall}, 0);
        chk("rst_ack",    {31'b0, dma_ack}, 0);
        chk("rst_stall_cnt", {16'b0, stall_cnt}, 0);
        @(posedge CLK); @(posedge CLK); #1;
        Reset = 0;
        @(negedge CLK);
        chk("post_rst_ack",   {31'b0, dma_ack}, 0);
        chk("post_rst_stall", {31'b0, cpu_stall}, 0);
        chk("post_rst_mem_a", mem_a, 32'h100);
        @(posedge CLK); #1;

        // Table vectors (first vector has dma_req low, clearing the wait count).
        for (int i = 0; i < 8; i++) begin
            cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cd;
            dma_req = tbl[i].dr; dma_we = tbl[i].dw; dma_addr = tbl[i].da; dma_wdata = tbl[i].dd;
            @(negedge CLK);
            chk($sformatf("v%0d_ack", i),   {31'b0, dma_ack},   {31'b0, tbl[i].ack});
            chk($sformatf("v%0d_stall", i), {31'b0, cpu_stall}, {31'b0, tbl[i].st});
            chk($sformatf("v%0d_we", i),    {31'b0, mem_we},    {31'b0, tbl[i].we});
            chk($sformatf("v%0d_a", i),     mem_a,     tbl[i].a);
            chk($sformatf("v%0d_wd", i),    mem_wd,    tbl[i].wd);
            chk($sformatf("v%0d_crd", i),   cpu_rdata, tbl[i].rd);
            chk($sformatf("v%0d_drd", i),   dma_rdata, tbl[i].rd);
            @(posedge CLK); #1;
        end

        // Starvation bound: CPU wins 4 cycles, DMA the 5th, repeating.
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h8; dma_req = 1; dma_we = 0; dma_addr = 32'h40;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            chk($sformatf("starve%0d_ack", c),   {31'b0, dma_ack},   {31'b0, c % 5 == 4});
            chk($sformatf("starve%0d_stall", c), {31'b0, cpu_stall}, {31'b0, c % 5 == 4});
            chk($sformatf("starve%0d_a", c),     mem_a, (c % 5 == 4) ? 32'h40 : 32'h8);
            @(posedge CLK); #1;
        end
        chk("starve_stall_cnt", {16'b0, stall_cnt}, 2);

        // CPU idle gaps: DMA acked in every idle cycle, never a stall.
        for (int c = 0; c < 8; c++) begin
            cpu_req = (c % 2 == 0);
            @(negedge CLK);
            chk($sformatf("gap%0d_ack", c),   {31'b0, dma_ack},   {31'b0, c % 2 == 1});
            chk($sformatf("gap%0d_stall", c), {31'b0, cpu_stall}, 0);
            @(posedge CLK); #1;
        end
        chk("gap_stall_cnt", {16'b0, stall_cnt}, 2);

        // Reset mid-wait: two lost cycles, then async reset mid-cycle.
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h8; cpu_wdata = 32'h7; dma_req = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            chk($sformatf("pre_rst%0d_ack", c), {31'b0, dma_ack}, 0);
            @(posedge CLK); #1;
        end
        Reset = 1; #1;
        chk("midrst_ack",   {31'b0, dma_ack}, 0);
        chk("midrst_stall", {31'b0, cpu_stall}, 0);
        chk("midrst_we",    {31'b0, mem_we}, 0);
        chk("midrst_stall_cnt", {16'b0, stall_cnt}, 0);
        @(posedge CLK); #1;
        Reset = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            chk($sformatf("rewait%0d_ack", c),   {31'b0, dma_ack},   {31'b0, c == 4});
            chk($sformatf("rewait%0d_stall", c), {31'b0, cpu_stall}, {31'b0, c == 4});
            @(posedge CLK); #1;
        end
        chk("rewait_stall_cnt", {16'b0, stall_cnt}, 1);
        cpu_req = 0; dma_req = 0;

        // Saturation on the STARVE_LIMIT=1 / 4-bit instance: stall every 2nd cycle.
        c2_req = 1; d2_req = 1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            chk($sformatf("sat%0d_ack", k),   {31'b0, dma_ack2},   {31'b0, k % 2 == 0});
            chk($sformatf("sat%0d_stall", k), {31'b0, cpu_stall2}, {31'b0, k % 2 == 0});
            chk($sformatf("sat%0d_a", k),     mem_a2, (k % 2 == 0) ? 32'h20 : 32'h10);
            chk($sformatf("sat%0d_we", k),    {31'b0, mem_we2},    {31'b0, k % 2 == 1});
            if (k == 1) begin
                chk("sat_wd",  mem_wd2,    32'h1);
                chk("sat_crd", cpu_rdata2, 32'h1234);
                chk("sat_drd", dma_rdata2, 32'h1234);
            end
            @(posedge CLK); #1;
            if (k == 29) chk("sat_cnt29", {28'b0, stall_cnt2}, 14);
            if (k == 30) chk("sat_cnt30", {28'b0, stall_cnt2}, 15);
            if (k == 40) chk("sat_cnt40", {28'b0, stall_cnt2}, 15);
        end
        c2_req = 0; d2_req = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the MIPS core's load/store port and an external DMA/loader port. The CPU has priority, and a bounded starvation counter guarantees the DMA port a slot. It sits between the core's ALUOut/WriteData/MemWrite/ReadData signals and the data memory. It stalls the core when the core loses arbitration and keeps a saturating count of stall cycles.

## Interface
- DATA_WIDTH, 32, width of data words and of all addresses
- STARVE_LIMIT, 4, maximum consecutive cycles a pending DMA request may lose to the CPU (legal range 1..255)
- STALL_CNT_WIDTH, 16, width of the stall-cycle counter

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU memory access request (load or store) this cycle
- cpu_we  in  1  CPU store (1) / load (0)
- cpu_addr  in  DATA_WIDTH  CPU byte address (ALUOut)
- cpu_wdata  in  DATA_WIDTH  CPU store data
- cpu_rdata  out  DATA_WIDTH  load data to the CPU
- cpu_stall  out  1  CPU lost arbitration; core must hold PC and the instruction
- dma_req  in  1  DMA access request; held until acknowledged
- dma_we  in  1  DMA write (1) / read (0)
- dma_addr  in  DATA_WIDTH  DMA byte address
- dma_wdata  in  DATA_WIDTH  DMA write data
- dma_rdata  out  DATA_WIDTH  read data to the DMA port
- dma_ack  out  1  DMA access performed this cycle
- mem_a  out  DATA_WIDTH  data memory address
- mem_we  out  1  data memory write enable
- mem_wd  out  DATA_WIDTH  data memory write data
- mem_rd  in  DATA_WIDTH  data memory read data (combinational read)
- stall_cnt  out  STALL_CNT_WIDTH  saturating count of cpu_stall cycles

## Operation
- Grant is decided combinationally each cycle from the inputs and the registered wait_cnt. Width of wait_cnt: clog2(STARVE_LIMIT+1).
- The DMA is granted when dma_req is high and either cpu_req is low or wait_cnt == STARVE_LIMIT.
- Otherwise the CPU is granted when cpu_req is high.
- With no request, there is no grant. In that case mem_a = cpu_addr, mem_wd = cpu_wdata and mem_we = 0.
- Mux: the granted requester drives mem_a/mem_wd. mem_we is the granted requester's we.
- cpu_rdata and dma_rdata both equal mem_rd at all times. Each is valid only in its owner's granted cycle.
- dma_ack = DMA granted. cpu_stall = cpu_req and the CPU is not granted.
- wait_cnt update on each edge:
  - cleared if the DMA is granted or dma_req is low;
  - otherwise, if the CPU is granted while dma_req is high, incremented, saturating at STARVE_LIMIT.
- stall_cnt increments on each edge where cpu_stall = 1. It saturates at all-ones and never wraps.
- A store is committed by the memory at the edge ending its granted cycle. The arbiter adds no write buffering.
- The DMA must keep dma_req/dma_we/dma_addr/dma_wdata stable until the cycle dma_ack = 1. Changing them earlier is a protocol violation with undefined results.
- After an ack, the DMA may drop dma_req, or keep it high to issue the next access, presenting new address/data in the following cycle.

## Timing
- Reset values: wait_cnt = 0 and stall_cnt = 0.
- While Reset = 1, dma_ack = 0, cpu_stall = 0 and mem_we = 0, overriding the grant logic. This is asynchronous: it takes effect immediately, mid-access.
- Zero-latency arbitration: an access is performed in the same cycle it is granted.
- DMA worst-case wait under continuous cpu_req: the DMA loses STARVE_LIMIT cycles and is acked in the next cycle, i.e. ack in cycle STARVE_LIMIT+1 after dma_req rises.
- A CPU stall lasts exactly 1 cycle per DMA grant while cpu_req is held.
- Simultaneous requests with wait_cnt < STARVE_LIMIT: the CPU wins, and wait_cnt increments at that edge.
- Back-to-back DMA requests against a continuous CPU: the pattern is STARVE_LIMIT CPU cycles, 1 DMA cycle, repeating. wait_cnt restarts from 0 after each ack.
- Reset asserted mid-wait: wait_cnt returns to 0. After release, the DMA again waits up to STARVE_LIMIT cycles.

## Test plan
- Reset: assert Reset with cpu_req = dma_req = 1, cpu_we = 1 -> mem_we = 0, cpu_stall = 0, dma_ack = 0, stall_cnt = 0; after release, the CPU is granted first.
- DMA alone: cpu_req = 0, dma_req = 1, dma_we = 1, dma_addr = 0x40, dma_wdata = 0xA5A5 -> dma_ack = 1 in the same cycle, mem_a = 0x40, mem_we = 1; a subsequent DMA read of 0x40 returns dma_rdata = 0xA5A5.
- Starvation bound (STARVE_LIMIT = 4): hold cpu_req = 1 and dma_req = 1 continuously -> the CPU is granted in cycles 1-4; in cycle 5 dma_ack = 1 and cpu_stall = 1; the pattern repeats with period 5; stall_cnt = 2 after 10 cycles.
- Simultaneous, no contention history: cpu_req = 1 (cpu_we = 1, addr 0x8, data 7) and dma_req = 1 both rise in the same cycle -> the CPU store is committed first, then the DMA is acked when the CPU request drops or after 4 cycles.
- CPU idle gaps: cpu_req alternates 1/0 with dma_req = 1 -> the DMA is acked in every cpu_req = 0 cycle, wait_cnt never exceeds 1, and cpu_stall stays 0.
- Counter saturation (STALL_CNT_WIDTH = 4, STARVE_LIMIT = 1): run 40 contended cycles -> stall_cnt reaches 15 and holds at 15.
